ro_freq_meter: RTL



---
 rtl/ro_freq_meter_if.sv | 34 +++
 rtl/ro_freq_meter.sv | 97 +++++++++
 2 files changed

// File: rtl/ro_freq_meter_if.sv
// Control/result bundle for the ring-oscillator frequency meter.
// The master side is software/glitch logic plus the oscillator pins; the slave side is the meter.
interface ro_freq_meter_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start;
  logic [WIN_W-1:0] window;
  logic [CNT_W-1:0] thr_short_lo;
  logic [CNT_W-1:0] thr_short_hi;
  logic [CNT_W-1:0] thr_long_lo;
  logic [CNT_W-1:0] thr_long_hi;
  logic             ro_short_q;
  logic             ro_long_q;
  logic             alarm_clr;
  logic             ro_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt_short;
  logic [CNT_W-1:0] cnt_long;
  logic [1:0]       alarm;

  modport master (
    output start, window, thr_short_lo, thr_short_hi, thr_long_lo, thr_long_hi,
           ro_short_q, ro_long_q, alarm_clr,
    input  ro_en, busy, done, cnt_short, cnt_long, alarm
  );

  modport slave (
    input  start, window, thr_short_lo, thr_short_hi, thr_long_lo, thr_long_hi,
           ro_short_q, ro_long_q, alarm_clr,
    output ro_en, busy, done, cnt_short, cnt_long, alarm
  );
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator pair, lets them settle,
// counts synchronized rising edges over a gate window, latches the counts and
// raises sticky out-of-band alarms.
module ro_freq_meter #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             mclk,
  input  logic             puc_rst_n,
  ro_freq_meter_if.slave   bus
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t           state;
  logic [SET_W-1:0] set_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cs, cl, cs_nxt, cl_nxt;
  logic [2:0]       sy_s, sy_l;   // [1:0] synchronizer, [2] edge-detect history
  logic             edge_s, edge_l, meas, fin;
  logic [1:0]       set_v;

  assign edge_s = sy_s[1] & ~sy_s[2];
  assign edge_l = sy_l[1] & ~sy_l[2];
  assign meas   = (state == MEASURE);
  // Last measure cycle: the window counter is loaded with W and counts down to 1.
  assign fin    = meas && (win_cnt == WIN_W'(1));

  // Saturating next-count; also feeds the result latch so the final cycle's edge is kept.
  assign cs_nxt = (meas && edge_s && (cs != '1)) ? cs + CNT_W'(1) : cs;
  assign cl_nxt = (meas && edge_l && (cl != '1)) ? cl + CNT_W'(1) : cl;

  // Band checks only matter on the completing edge; lo > hi makes every count fail.
  assign set_v[0] = fin && ((cs_nxt < bus.thr_short_lo) || (cs_nxt > bus.thr_short_hi));
  assign set_v[1] = fin && ((cl_nxt < bus.thr_long_lo)  || (cl_nxt > bus.thr_long_hi));

  // Measurement FSM with synchronizers, counters and registered outputs.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state         <= IDLE;
      set_cnt       <= '0;
      win_cnt       <= '0;
      cs            <= '0;
      cl            <= '0;
      sy_s          <= '0;
      sy_l          <= '0;
      bus.ro_en     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.cnt_short <= '0;
      bus.cnt_long  <= '0;
      bus.alarm     <= 2'b00;
    end else begin
      sy_s      <= {sy_s[1:0], bus.ro_short_q};
      sy_l      <= {sy_l[1:0], bus.ro_long_q};
      bus.done  <= 1'b0;
      // A set on the completing edge wins over a simultaneous clear.
      bus.alarm <= (bus.alarm & {2{~bus.alarm_clr}}) | set_v;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= SETTLE;
            set_cnt   <= SET_W'(SETTLE_CYC);
            // Window is captured here and held through SETTLE; 0 means 1.
            win_cnt   <= (bus.window == '0) ? WIN_W'(1) : bus.window;
            cs        <= '0;
            cl        <= '0;
            bus.ro_en <= 1'b1;
            bus.busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (set_cnt == SET_W'(1)) state <= MEASURE;
          else                      set_cnt <= set_cnt - SET_W'(1);
        end
        MEASURE: begin
          cs <= cs_nxt;
          cl <= cl_nxt;
          if (fin) begin
            state         <= DONE;
            bus.ro_en     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.cnt_short <= cs_nxt;
            bus.cnt_long  <= cl_nxt;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
